nor_logic_seq: RTL and testbench

Multi-cycle logic sequencer that computes eight bitwise functions of two 32-bit operands using one shared `nor_32` instance, one NOR pass per clock. NOR is universal, so the block reuses a single gate array for OR, AND, XOR and the other functions instead of building separate gate arrays. It sits between the register-file read ports and the result writeback mux of the datapath as the logic-function unit.

---
 rtl/nor_seq_pkg.sv | 89 ++++++++
 rtl/nor_32.sv | 8 +
 rtl/nor_logic_seq.sv | 135 +++++++++++++
 tb/tb_nor_logic_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nor_seq_pkg.sv
// Shared definitions for the NOR-based logic sequencer: opcodes, pass counts,
// operand/destination encodings and the per-pass microcode table.
package nor_seq_pkg;

  localparam int W = 32;

  localparam logic [2:0] OP_NOR  = 3'd0;
  localparam logic [2:0] OP_NOTA = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_BUFA = 3'd7;

  typedef enum logic [1:0] {SEL_A, SEL_B, SEL_T1, SEL_T2} sel_e;
  typedef enum logic [1:0] {DST_T1, DST_T2, DST_R} dst_e;
  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  typedef struct packed {
    sel_e x0;
    sel_e x1;
    dst_e dest;
    logic last;
  } ucode_t;

  function automatic logic [2:0] pass_count(logic [2:0] op);
    logic [2:0] n;
    case (op)
      OP_NOR:  n = 3'd1;
      OP_NOTA: n = 3'd1;
      OP_OR:   n = 3'd2;
      OP_AND:  n = 3'd3;
      OP_NAND: n = 3'd4;
      OP_XOR:  n = 3'd5;
      OP_XNOR: n = 3'd6;
      default: n = 3'd2;
    endcase
    return n;
  endfunction

  function automatic ucode_t mk(sel_e x0, sel_e x1, dst_e dest);
    ucode_t u;
    u.x0   = x0;
    u.x1   = x1;
    u.dest = dest;
    u.last = 1'b0;
    return u;
  endfunction

  // Operand/destination for pass 'step' of 'op'; 'last' marks the result pass.
  function automatic ucode_t pass_ucode(logic [2:0] op, logic [2:0] step);
    ucode_t u;
    u = mk(SEL_A, SEL_A, DST_R);
    case (op)
      OP_NOR:  u = mk(SEL_A, SEL_B, DST_R);
      OP_NOTA: u = mk(SEL_A, SEL_A, DST_R);
      OP_OR:
        case (step)
          3'd0:    u = mk(SEL_A, SEL_B, DST_T1);
          default: u = mk(SEL_T1, SEL_T1, DST_R);
        endcase
      OP_AND, OP_NAND:
        case (step)
          3'd0:    u = mk(SEL_A, SEL_A, DST_T1);
          3'd1:    u = mk(SEL_B, SEL_B, DST_T2);
          3'd2:    u = mk(SEL_T1, SEL_T2, (op == OP_AND) ? DST_R : DST_T1);
          default: u = mk(SEL_T1, SEL_T1, DST_R);
        endcase
      OP_XOR, OP_XNOR:
        case (step)
          3'd0:    u = mk(SEL_A, SEL_A, DST_T1);
          3'd1:    u = mk(SEL_B, SEL_B, DST_T2);
          3'd2:    u = mk(SEL_T1, SEL_T2, DST_T1);
          3'd3:    u = mk(SEL_A, SEL_B, DST_T2);
          3'd4:    u = mk(SEL_T1, SEL_T2, (op == OP_XOR) ? DST_R : DST_T1);
          default: u = mk(SEL_T1, SEL_T1, DST_R);
        endcase
      default:
        case (step)
          3'd0:    u = mk(SEL_A, SEL_A, DST_T1);
          default: u = mk(SEL_T1, SEL_T1, DST_R);
        endcase
    endcase
    u.last = (step == pass_count(op) - 3'd1);
    return u;
  endfunction

endpackage

// File: rtl/nor_32.sv
// 32-bit bitwise NOR gate array shared by every pass of the sequencer.
module nor_32 (
  output logic [31:0] res,
  input  logic [31:0] a,
  input  logic [31:0] b
);
  assign res = ~(a | b);
endmodule

// File: rtl/nor_logic_seq.sv
// Multi-cycle logic-function unit: eight bitwise ops built from one NOR pass
// per clock. Optional abort input enabled by NOR_SEQ_ABORT_EN.
module nor_logic_seq
  import nor_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
`ifdef NOR_SEQ_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
);

  // Handshake: start is taken on a rising edge only while busy=0; done is a
  // single-cycle pulse in an idle cycle, so a new start may share that cycle.

  state_e       state_q, state_d;
  logic [W-1:0] ra_q, ra_d, rb_q, rb_d;
  logic [W-1:0] t1_q, t1_d, t2_q, t2_d;
  logic [W-1:0] result_q, result_d;
  logic [2:0]   step_q, step_d;
  logic [2:0]   rop_q, rop_d;
  logic         done_q, done_d;

  ucode_t       uc;
  logic [W-1:0] x0, x1, y;
  logic         abort_hit;

`ifdef NOR_SEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign uc = pass_ucode(rop_q, step_q);

  always_comb begin
    x0 = ra_q;
    x1 = ra_q;
    case (uc.x0)
      SEL_A:   x0 = ra_q;
      SEL_B:   x0 = rb_q;
      SEL_T1:  x0 = t1_q;
      default: x0 = t2_q;
    endcase
    case (uc.x1)
      SEL_A:   x1 = ra_q;
      SEL_B:   x1 = rb_q;
      SEL_T1:  x1 = t1_q;
      default: x1 = t2_q;
    endcase
  end

  nor_32 u_nor (
    .res (y),
    .a   (x0),
    .b   (x1)
  );

  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    t1_d     = t1_q;
    t2_d     = t2_q;
    result_d = result_q;
    step_d   = step_q;
    rop_d    = rop_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          rop_d   = op;
          step_d  = 3'd0;
          state_d = ST_RUN;
        end
      end
      default: begin
        // Abort beats the final pass: nothing is written, no done.
        if (abort_hit) begin
          state_d = ST_IDLE;
        end else begin
          case (uc.dest)
            DST_T1:  t1_d     = y;
            DST_T2:  t2_d     = y;
            default: result_d = y;
          endcase
          if (uc.last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ra_q     <= '0;
      rb_q     <= '0;
      t1_q     <= '0;
      t2_q     <= '0;
      result_q <= '0;
      step_q   <= '0;
      rop_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      t1_q     <= t1_d;
      t2_q     <= t2_d;
      result_q <= result_d;
      step_q   <= step_d;
      rop_q    <= rop_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_nor_logic_seq.sv
// Scoreboard bench for nor_logic_seq: driver pushes model results on accepted
// starts, a negedge monitor pops and compares on every done pulse.
module tb_nor_logic_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
`ifdef NOR_SEQ_ABORT_EN
  logic         abort = 1'b0;
`endif
  logic         busy, done;
  logic [W-1:0] result;

  int compared = 0;
  int mismatched = 0;
  logic [W-1:0] exp_q[$];
  int lat_q[$];
  int beg_q[$];
  int cyc = 0;
  int busy_run = 0;
  logic [W-1:0] last_result = '0;

  nor_logic_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
`ifdef NOR_SEQ_ABORT_EN
    .abort  (abort),
`endif
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(logic [2:0] o, logic [W-1:0] x, logic [W-1:0] y);
    case (o)
      3'd0:    return ~(x | y);
      3'd1:    return ~x;
      3'd2:    return x | y;
      3'd3:    return x & y;
      3'd4:    return ~(x & y);
      3'd5:    return x ^ y;
      3'd6:    return ~(x ^ y);
      default: return x;
    endcase
  endfunction

  function automatic int passes(logic [2:0] o);
    case (o)
      3'd0, 3'd1: return 1;
      3'd2, 3'd7: return 2;
      3'd3:       return 3;
      3'd4:       return 4;
      3'd5:       return 5;
      default:    return 6;
    endcase
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic issue(logic [2:0] o, logic [W-1:0] x, logic [W-1:0] y);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    if (!busy) begin
      exp_q.push_back(model(o, x, y));
      lat_q.push_back(passes(o));
      beg_q.push_back(cyc + 1);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      a = $urandom;
      b = $urandom;
      op = 3'($urandom_range(0, 7));
      @(negedge clk);
      n++;
    end
    if (busy) begin
      compared++;
      mismatched++;
      $display("FAIL busy_timeout: busy still 1 after %0d cycles", n);
    end
  endtask

  task automatic drop_last();
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    void'(beg_q.pop_back());
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_run++;
      if (done) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: result %h with empty queue", result);
        end else begin
          logic [W-1:0] e;
          int l, s;
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          s = beg_q.pop_front();
          check("result", result, e);
          check_int("latency", cyc - s, l);
          check_int("busy_cycles", busy_run, l);
          check("busy_at_done", {31'd0, busy}, '0);
          last_result = e;
        end
        busy_run = 0;
      end else begin
        check("result_hold", result, last_result);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] dir_exp [8] = '{32'hFFFFFFC4, 32'hFFFFFFC6, 32'h0000003B, 32'h00000001,
                                32'hFFFFFFFE, 32'h0000003A, 32'hFFFFFFC5, 32'h00000039};

  initial begin
    #1;
    check("reset_busy", {31'd0, busy}, '0);
    check("reset_done", {31'd0, done}, '0);
    check("reset_result", result, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // directed ops with fixed operands
    for (int i = 0; i < 8; i++) begin
      issue(3'(i), 32'h39, 32'h3);
      wait_idle();
      check("directed", result, dir_exp[i]);
      @(negedge clk);
    end

    // start while busy must be ignored
    issue(3'd5, 32'h2, 32'h1);
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'hFFFFFFFF; b = 32'h0;
    check("busy_mid", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("busy_protect", result, 32'h3);
    @(negedge clk);

    // back-to-back: AND started in the done cycle of an OR
    issue(3'd2, $urandom, $urandom);
    wait_idle();
    check("b2b_done_cycle", {31'd0, done}, 32'd1);
    issue(3'd3, 32'hF0F0F0F0, 32'hFF00FF00);
    wait_idle();
    check("b2b_and", result, 32'hF000F000);

    // randomized ops with random gaps
    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), $urandom, $urandom);
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // asynchronous reset mid-sequence
    issue(3'd5, $urandom, $urandom);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, busy}, '0);
    check("rst_mid_done", {31'd0, done}, '0);
    check("rst_mid_result", result, '0);
    exp_q.delete(); lat_q.delete(); beg_q.delete();
    last_result = '0;
    busy_run = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'd0, 32'h0F0F1234, 32'h00FF0001);
    wait_idle();
    check("post_rst_nor", result, 32'hF000EDCA);
    @(negedge clk);

`ifdef NOR_SEQ_ABORT_EN
    // abort during XNOR at step 3
    issue(3'd6, 32'h39, 32'h3);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    drop_last();
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, '0);
    busy_run = 0;
    repeat (3) @(negedge clk);
    check("abort_result", result, last_result);

    // abort on the last pass of XOR
    issue(3'd5, 32'hAAAA5555, 32'h0F0F0F0F);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    drop_last();
    @(negedge clk);
    abort = 1'b0;
    check("abort_last_busy", {31'd0, busy}, '0);
    busy_run = 0;
    repeat (2) @(negedge clk);
    check("abort_last_result", result, last_result);

    // abort in idle is ignored; abort with start lets start win
    abort = 1'b1;
    @(negedge clk);
    issue(3'd2, 32'h00F0, 32'h0F00);
    abort = 1'b0;
    wait_idle();
    check("abort_idle_or", result, 32'h0FF0);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    check_int("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
